// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - UART bootloader: 8N1 receiver feeding a framed word loader
// Holds the CPU in reset while it writes little-endian words over the external memory port.
module uart_mem_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 256,
  parameter int          TIMEOUT_CLKS = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, DONE, ERR} state_t;

  rx_state_t rx_state, rx_nxt;
  state_t    state, state_nxt;

  logic          rx_meta, rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    byte_data;
  logic          byte_valid, frame_err;

  logic [TW-1:0] tmo_cnt;
  logic [7:0]    cnt_lo;
  logic [15:0]   n_total;
  logic [1:0]    byte_idx;
  logic [23:0]   word_lo;
  logic          is_hdr, timed_out;
  logic [15:0]   n_word;

  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_nxt = RX_START;
      RX_START: if (clk_cnt == HALF_LAST) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (clk_cnt == BIT_LAST && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (clk_cnt == BIT_LAST) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // clk_cnt restarts on every RX state change so the START half-bit lands DATA sampling mid-bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= uart_rx;
      rx_s       <= rx_meta;
      rx_state   <= rx_nxt;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_nxt != rx_state || clk_cnt == BIT_LAST) clk_cnt <= '0;
      else clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && clk_cnt == BIT_LAST) begin
        byte_data <= {rx_s, byte_data[7:1]};
        bit_idx   <= bit_idx + 1'b1;
      end
      if (rx_state == RX_STOP && clk_cnt == BIT_LAST) begin
        if (rx_s) byte_valid <= 1'b1;
        else      frame_err  <= 1'b1;
      end
    end
  end

  assign is_hdr    = byte_valid && (byte_data == 8'hA5);
  assign timed_out = (tmo_cnt == TMO_LAST) && !byte_valid;
  assign n_word    = {byte_data, cnt_lo};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (is_hdr) state_nxt = CNT_LO;
      CNT_LO: begin
        if (frame_err || timed_out) state_nxt = ERR;
        else if (byte_valid)        state_nxt = CNT_HI;
      end
      CNT_HI: begin
        if (frame_err || timed_out) state_nxt = ERR;
        else if (byte_valid) begin
          if (n_word == 16'd0)               state_nxt = DONE;
          else if ({1'b0, n_word} > MAX_N)   state_nxt = ERR;
          else                               state_nxt = DATA;
        end
      end
      DATA: begin
        if (frame_err || timed_out)              state_nxt = ERR;
        else if (byte_valid && byte_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE:   state_nxt = (words_loaded + 16'd1 == n_total) ? DONE : DATA;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data registers are loaded with the 4th byte so they are stable across the WRITE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      cnt_lo        <= '0;
      n_total       <= '0;
      byte_idx      <= '0;
      word_lo       <= '0;
      words_loaded  <= '0;
      Ext_WriteData <= '0;
      Ext_DataAdr   <= '0;
    end else begin
      state <= state_nxt;
      if (byte_valid || state_nxt != state) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
      if ((state == IDLE || state == DONE || state == ERR) && is_hdr) words_loaded <= '0;
      if (state == CNT_LO && byte_valid) cnt_lo <= byte_data;
      if (state == CNT_HI && byte_valid) begin
        n_total  <= n_word;
        byte_idx <= '0;
      end
      if (state == DATA && byte_valid) begin
        word_lo  <= {byte_data, word_lo[23:8]};
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) begin
          Ext_WriteData <= {byte_data, word_lo};
          Ext_DataAdr   <= ADDR_BASE + {14'b0, words_loaded, 2'b00};
        end
      end
      if (state == WRITE) words_loaded <= words_loaded + 16'd1;
    end
  end

  assign Ext_MemWrite = (state == WRITE);
  assign cpu_reset    = (state != DONE);
  assign load_done    = (state == DONE);
  assign load_err     = (state == ERR);

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - self-checking bench for uart_mem_loader
// Directed plus randomized frames compared against a frame-level write model.
module tb_uart_mem_loader;
  localparam int          CPB  = 4;
  localparam int          MAXW = 4;
  localparam int          TMO  = 100;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        uart_rx = 1'b1;
  logic        cpu_reset, mem_write, load_done, load_err;
  logic [31:0] wdata, adr;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [63:0] got_q[$];
  logic [31:0] fw[0:7];
  int          fn;

  always #5 clk = ~clk;

  uart_mem_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_BASE(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .reset(rst_n), .uart_rx(uart_rx), .cpu_reset(cpu_reset),
    .Ext_MemWrite(mem_write), .Ext_WriteData(wdata), .Ext_DataAdr(adr),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      got_q.push_back({adr, wdata});
      check("strobe_in_reset", 32'(cpu_reset), 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i]; tick(CPB);
    end
    uart_rx = stop; tick(CPB);
    uart_rx = 1'b1; tick(1);
  endtask

  task automatic send_frame();
    logic [15:0] n16;
    n16 = 16'(fn);
    send_byte(8'hA5);
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    if (fn <= MAXW)
      for (int i = 0; i < fn; i++)
        for (int k = 0; k < 4; k++) send_byte(fw[i][8*k +: 8]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, ".memwrite"}, 32'(mem_write), 32'd0);
    check({tag, ".wdata"}, wdata, 32'd0);
    check({tag, ".adr"}, adr, 32'd0);
    check({tag, ".done"}, 32'(load_done), 32'd0);
    check({tag, ".err"}, 32'(load_err), 32'd0);
    check({tag, ".words"}, 32'(words_loaded), 32'd0);
  endtask

  // Model: count 0 completes empty, count above MAXW is rejected, else word i lands at BASE+4*i
  task automatic expect_frame(input string tag);
    int   en;
    logic exp_done, exp_err;
    tick(4);
    if (fn == 0)         begin en = 0;  exp_done = 1'b1; exp_err = 1'b0; end
    else if (fn > MAXW)  begin en = 0;  exp_done = 1'b0; exp_err = 1'b1; end
    else                 begin en = fn; exp_done = 1'b1; exp_err = 1'b0; end
    check({tag, ".nwr"}, 32'(got_q.size()), 32'(en));
    for (int i = 0; i < en && i < got_q.size(); i++) begin
      check({tag, ".adr"}, got_q[i][63:32], BASE + 32'(4 * i));
      check({tag, ".data"}, got_q[i][31:0], fw[i]);
    end
    check({tag, ".done"}, 32'(load_done), 32'(exp_done));
    check({tag, ".err"}, 32'(load_err), 32'(exp_err));
    check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    check({tag, ".words"}, 32'(words_loaded), 32'(en));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(5);

    got_q.delete(); fn = 2; fw[0] = 32'h0050_0513; fw[1] = 32'h00A5_85B3;
    send_frame(); expect_frame("two_word");

    got_q.delete(); fn = 0;
    send_frame(); expect_frame("zero_count");

    got_q.delete(); fn = 5;
    send_frame(); expect_frame("over_max");
    got_q.delete(); fn = 1; fw[0] = 32'hDEAD_BEEF;
    send_frame(); expect_frame("after_err");

    got_q.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33, 1'b0);
    tick(20);
    check("bad_stop.err", 32'(load_err), 32'd1);
    check("bad_stop.nwr", 32'(got_q.size()), 32'd0);
    check("bad_stop.cpu_reset", 32'(cpu_reset), 32'd1);

    got_q.delete(); fn = 1; fw[0] = 32'h5566_7788;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    tick(10); uart_rx = 1'b0; tick(1); uart_rx = 1'b1; tick(20);
    for (int k = 0; k < 4; k++) send_byte(fw[0][8*k +: 8]);
    expect_frame("glitch");

    got_q.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    tick(80);
    check("timeout.early", 32'(load_err), 32'd0);
    tick(35);
    check("timeout.err", 32'(load_err), 32'd1);
    check("timeout.nwr", 32'(got_q.size()), 32'd0);

    got_q.delete(); fn = 2; fw[0] = 32'hCAFE_F00D; fw[1] = 32'h1234_5678;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    for (int k = 0; k < 4; k++) send_byte(fw[0][8*k +: 8]);
    tick(4);
    check("midreset.pre_words", 32'(words_loaded), 32'd1);
    check("midreset.pre_wdata", wdata, 32'hCAFE_F00D);
    uart_rx = 1'b0; tick(CPB);
    uart_rx = 1'b1; tick(2 * CPB);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    tick(3);
    rst_n = 1'b1;
    tick(4);
    for (int k = 0; k < 4; k++) send_byte(fw[1][8*k +: 8]);
    tick(4);
    check("discard.nwr", 32'(got_q.size()), 32'd1);
    check("discard.cpu_reset", 32'(cpu_reset), 32'd1);
    check("discard.done", 32'(load_done), 32'd0);
    got_q.delete(); fn = 1; fw[0] = 32'h0BAD_C0DE;
    send_frame(); expect_frame("post_reset");

    for (int r = 0; r < 6; r++) begin
      got_q.delete();
      fn = int'($urandom_range(0, 6));
      for (int i = 0; i < 8; i++) fw[i] = $urandom;
      send_frame(); expect_frame("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
